nibble_serial_adder: RTL and testbench



---
 rtl/nibble_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_fulladder4.sv | 23 ++
 rtl/nibble_serial_adder.sv | 138 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
// Exports: state_e, NIBBLE_W, nibbles().
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_fulladder4.sv
// 4-bit ripple-carry adder slice, shared by the serial sequencer.
// Ports: a_i, b_i, carry_i in; sum_o, carry_o out.
module fulladder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  logic [4:0] w_c;

  assign w_c[0] = carry_i;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum_o[i]  = a_i[i] ^ b_i[i] ^ w_c[i];
    assign w_c[i+1]  = (a_i[i] & b_i[i])
                     | (w_c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/sub done one nibble per cycle through a 4-bit slice.
// Ports: req valid/ready + operands in, rsp valid/ready + sum/flags out.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int NIB = nibbles(WIDTH);
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 8");
  end

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;

  logic [3:0]       w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_b_in;
  logic [WIDTH-1:0] w_fin;

  fulladder4 u_slice (
    .a_i     (r_a[3:0]),
    .b_i     (r_b[3:0]),
    .carry_i (r_c),
    .sum_o   (w_s),
    .carry_o (w_co)
  );

  assign w_last = (r_cnt == LAST);
  assign w_b_in = sub_i ? ~b_i : b_i;
  assign w_fin  = {w_s, r_acc[WIDTH-1:NIBBLE_W]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_next = CALC;
      end
      CALC: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Result registers load only on the last slice so the visible
  // outputs keep the previous answer while a new one is computed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_a     <= a_i;
            r_b     <= w_b_in;
            r_c     <= sub_i | carry_i;
            r_a_msb <= a_i[WIDTH-1];
            r_b_msb <= w_b_in[WIDTH-1];
            r_cnt   <= '0;
          end
        end
        CALC: begin
          r_a   <= r_a >> NIBBLE_W;
          r_b   <= r_b >> NIBBLE_W;
          r_acc <= w_fin;
          r_c   <= w_co;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= w_fin;
            r_carry <= w_co;
            r_ovf   <= (r_a_msb == r_b_msb)
                     & (w_fin[WIDTH-1] != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_o      = r_sum;
  assign carry_o    = r_carry;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder, WIDTH=32.
// Each task drives one scenario and checks its own results.
module tb_nibble_serial_adder;

  localparam int LAT = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .a_i         (a),
    .b_i         (b),
    .carry_i     (cin),
    .sub_i       (sub),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .sum_o       (sum),
    .carry_o     (cout),
    .overflow_o  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for rsp_valid; lat = cycles after accept.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob,
                       input logic os, input logic oc,
                       output int lat);
    req_valid = 1'b1;
    a = oa;
    b = ob;
    sub = os;
    cin = oc;
    tick();
    req_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    sub = ~os;
    cin = ~oc;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        sub;
    logic        cin;
    logic        c;
    logic        v;
  } vec_t;

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: ready=%b valid=%b, want 1 0",
               req_ready, rsp_valid);
    end
    checks++;
    if (sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: sum=%h c=%b v=%b, want 0 0 0",
               sum, cout, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    vec_t v[6];
    int lat;
    v[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,
             1'b0, 1'b0, 1'b1, 1'b0};
    v[1] = '{32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE,
             1'b1, 1'b1, 1'b0, 1'b0};
    v[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000,
             1'b0, 1'b0, 1'b0, 1'b1};
    v[3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
             1'b1, 1'b0, 1'b1, 1'b1};
    v[4] = '{32'h0000_000F, 32'h0000_0000, 32'h0000_0010,
             1'b0, 1'b1, 1'b0, 1'b0};
    v[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568,
             1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(v[i].a, v[i].b, v[i].sub, v[i].cin, lat);
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL arith%0d_lat: got %0d cycles, want %0d",
                 i, lat, LAT);
      end
      checks++;
      if (sum !== v[i].s || cout !== v[i].c || ovf !== v[i].v) begin
        errors++;
        $display("FAIL arith%0d_res: sum=%h c=%b v=%b, want %h %b %b",
                 i, sum, cout, ovf, v[i].s, v[i].c, v[i].v);
      end
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL arith%0d_busy: req_ready=%b, want 0",
                 i, req_ready);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1
          || sum !== v[i].s) begin
        errors++;
        $display("FAIL arith%0d_idle: valid=%b ready=%b sum=%h, want 0 1 %h",
                 i, rsp_valid, req_ready, sum, v[i].s);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== LAT || sum !== 32'h3) begin
      errors++;
      $display("FAIL bp_first: lat=%0d sum=%h, want %0d 00000003",
               lat, sum, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0];
      a = 32'hA5A5_0000 + 32'(i);
      b = 32'h0F0F_0F0F;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0
          || sum !== 32'h3 || cout !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b ready=%b sum=%h c=%b v=%b, want 1 0 00000003 0 0",
                 i, rsp_valid, req_ready, sum, cout, ovf);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b, want 0 1",
               rsp_valid, req_ready);
    end
    do_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== LAT || sum !== 32'h30) begin
      errors++;
      $display("FAIL bp_next: lat=%0d sum=%h, want %0d 00000030",
               lat, sum, LAT);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    req_valid = 1'b1;
    a = 32'h0000_0100;
    b = 32'h0000_0200;
    sub = 1'b0;
    cin = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || sum !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_state: valid=%b ready=%b sum=%h, want 0 1 00000000",
               rsp_valid, req_ready, sum);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_norsp: got a response, want none");
    end
    do_op(32'h0000_0ABC, 32'h0000_0123, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== LAT || sum !== 32'h0000_0999 || cout !== 1'b1
        || ovf !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_fresh: lat=%0d sum=%h c=%b v=%b, want %0d 00000999 1 0",
               lat, sum, cout, ovf, LAT);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
